pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage pipelined RISC-V core. It decides operand forwarding for the Execute-stage ALU, load-use stalls, and branch/jump flushes driven by `PCSrcE`. It also runs a small FSM that freezes the whole pipeline during a multi-cycle data-memory access, with timeout detection. Stall and flush counters are kept for bring-up.

---
 rtl/pipeline_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage RISC-V pipeline:
// operand forwarding, load-use stalls, branch flushes and a memory-wait freeze FSM.
module pipeline_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemDoneM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MemStartM,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

  state_t        state, state_next;
  logic [WW-1:0] wait_cnt, wait_cnt_next;
  logic          freeze, mem_start, err_set, timeout_hit, lw_stall;

  // Memory-stage result wins over Writeback since it is the younger value.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic wr_m, input logic [4:0] rd_m,
                                         input logic wr_w, input logic [4:0] rd_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    else                                              return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((Rs1D == RdE) || (Rs2D == RdE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Freeze is released in the completion or timeout cycle so the pipeline advances at that edge.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    freeze        = 1'b0;
    mem_start     = 1'b0;
    err_set       = 1'b0;
    timeout_hit   = (wait_cnt == WW'(TIMEOUT - 1));
    case (state)
      RUN: begin
        if (MemReqM) begin
          mem_start     = 1'b1;
          freeze        = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = '0;
        end
      end
      MEM_WAIT: begin
        if (MemDoneM) begin
          state_next = RUN;
        end else if (timeout_hit) begin
          err_set    = 1'b1;
          state_next = RUN;
        end else begin
          freeze        = 1'b1;
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign MemStartM = rst_n & mem_start;
  assign StallF    = rst_n & (freeze | lw_stall);
  assign StallD    = rst_n & (freeze | lw_stall);
  assign StallE    = rst_n & freeze;
  assign StallM    = rst_n & freeze;
  assign StallW    = rst_n & freeze;
  assign FlushD    = rst_n & ~freeze & PCSrcE;
  assign FlushE    = rst_n & ~freeze & (lw_stall | PCSrcE);

  // Counters saturate at all-ones; MemErr is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
      MemErr     <= 1'b0;
    end else begin
      if ((freeze || lw_stall) && (StallCount != '1))
        StallCount <= StallCount + 1'b1;
      if (!freeze && PCSrcE && (FlushCount != '1))
        FlushCount <= FlushCount + 1'b1;
      if (err_set)
        MemErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// stimulus compared against a behavioural model of the controller.
module tb_pipeline_ctrl;

  localparam int T   = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]    ResultSrcE;
  logic          PCSrcE, RegWriteM, RegWriteW, MemReqM, MemDoneM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
  logic          MemStartM, MemErr;
  logic [CW-1:0] StallCount, FlushCount;

  int checks = 0;
  int errors = 0;

  // Model state: whether an access is outstanding, how many wait cycles it has used, and the counters.
  bit m_wait, m_err, m_freeze, m_lw, m_done, m_tout;
  int m_waited, m_sc, m_fc;

  pipeline_ctrl #(.TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemDoneM(MemDoneM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .MemStartM(MemStartM), .MemErr(MemErr),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] refFwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [4:0] stalls();
    return {StallF, StallD, StallE, StallM, StallW};
  endfunction

  task automatic clearInputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    ResultSrcE = 2'b00;
    {PCSrcE, RegWriteM, RegWriteW, MemReqM, MemDoneM} = '0;
  endtask

  task automatic applyStimulus();
    Rs1D = 5'($urandom_range(0, 3));
    Rs2D = 5'($urandom_range(0, 3));
    Rs1E = 5'($urandom_range(0, 3));
    Rs2E = 5'($urandom_range(0, 3));
    RdE  = 5'($urandom_range(0, 3));
    RdM  = 5'($urandom_range(0, 3));
    RdW  = 5'($urandom_range(0, 3));
    ResultSrcE = 2'($urandom_range(0, 3));
    PCSrcE    = ($urandom_range(0, 4) == 0);
    RegWriteM = ($urandom_range(0, 1) == 0);
    RegWriteW = ($urandom_range(0, 1) == 0);
    MemReqM   = ($urandom_range(0, 7) == 0);
    MemDoneM  = ($urandom_range(0, 3) == 0);
  endtask

  // Compare every output against the model in the middle of the cycle.
  task automatic evalCycle();
    logic [4:0] es;
    bit start;
    @(negedge clk);
    m_lw   = (ResultSrcE == 2'b01) && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
    m_done = m_wait && MemDoneM;
    m_tout = m_wait && !MemDoneM && (m_waited == T - 1);
    start  = !m_wait && MemReqM;
    m_freeze = m_wait ? !(m_done || m_tout) : MemReqM;
    es = m_freeze ? 5'b11111 : (m_lw ? 5'b11000 : 5'b00000);
    checkOutput("fwdA", ForwardAE, refFwd(Rs1E));
    checkOutput("fwdB", ForwardBE, refFwd(Rs2E));
    checkOutput("stalls", stalls(), es);
    checkOutput("flushD", FlushD, !m_freeze && PCSrcE);
    checkOutput("flushE", FlushE, !m_freeze && (PCSrcE || m_lw));
    checkOutput("memStart", MemStartM, start);
    checkOutput("memErr", MemErr, m_err);
    checkOutput("stallCnt", StallCount, m_sc);
    checkOutput("flushCnt", FlushCount, m_fc);
  endtask

  task automatic advance();
    @(posedge clk);
    if (m_freeze || m_lw) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
    if (!m_freeze && PCSrcE) m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
    if (!m_wait) begin
      if (MemReqM) begin
        m_wait   = 1;
        m_waited = 0;
      end
    end else if (m_done) begin
      m_wait = 0;
    end else if (m_tout) begin
      m_wait = 0;
      m_err  = 1;
    end else begin
      m_waited++;
    end
    #1;
  endtask

  // Reset is asserted off the clock edge to exercise the asynchronous path.
  task automatic doReset();
    rst_n = 1'b0;
    #2;
    m_wait = 0; m_waited = 0; m_err = 0; m_sc = 0; m_fc = 0;
    checkOutput("rstStalls", stalls(), 5'b0);
    checkOutput("rstFlush", {FlushD, FlushE}, 2'b00);
    checkOutput("rstStart", MemStartM, 1'b0);
    checkOutput("rstErr", MemErr, 1'b0);
    checkOutput("rstCounts", {StallCount, FlushCount}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clearInputs();
    @(posedge clk);
    #1;
    doReset();

    // Forwarding priority
    RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 1; RegWriteW = 1;
    evalCycle(); checkOutput("fwdMem", ForwardAE, 2'b10); advance();
    RegWriteM = 0;
    evalCycle(); checkOutput("fwdWb", ForwardAE, 2'b01); advance();
    RegWriteM = 1; RdM = 0; RdW = 0;
    evalCycle(); checkOutput("fwdZero", ForwardAE, 2'b00); advance();
    clearInputs();

    // Load-use hazard
    ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
    evalCycle();
    checkOutput("lwStallFD", {StallF, StallD, FlushE, FlushD}, 4'b1110);
    advance();
    checkOutput("lwCount", StallCount, 1);
    RdE = 0;
    evalCycle(); checkOutput("lwRd0", {StallF, StallD, FlushE}, 3'b000); advance();

    // Branch flush together with a load-use hazard
    RdE = 3; PCSrcE = 1;
    evalCycle();
    checkOutput("brFlush", {FlushD, FlushE, StallF}, 3'b111);
    checkOutput("brCnt0", FlushCount, 0);
    advance();
    checkOutput("brCnt1", FlushCount, 1);
    clearInputs();

    // Memory wait completing three cycles after issue
    doReset();
    MemReqM = 1;
    evalCycle(); checkOutput("mwStart", MemStartM, 1'b1); advance();
    MemReqM = 0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) PCSrcE = 1;
      evalCycle();
      checkOutput("mwFrozen", stalls(), 5'b11111);
      checkOutput("mwNoStart", MemStartM, 1'b0);
      checkOutput("mwNoFlush", FlushD, 1'b0);
      advance();
    end
    MemDoneM = 1;
    evalCycle();
    checkOutput("mwDone", stalls(), 5'b0);
    checkOutput("mwLateFlush", FlushD, 1'b1);
    advance();
    clearInputs();
    checkOutput("mwCount", StallCount, 3);

    // Timeout without completion
    doReset();
    MemReqM = 1;
    evalCycle(); advance();
    MemReqM = 0;
    for (int i = 0; i < 3; i++) begin
      evalCycle(); checkOutput("toFrozen", stalls(), 5'b11111); advance();
    end
    evalCycle(); checkOutput("toRelease", stalls(), 5'b0); advance();
    checkOutput("toErr", MemErr, 1'b1);
    for (int i = 0; i < 3; i++) begin
      evalCycle(); checkOutput("toSticky", {MemErr, stalls()}, 6'b100000); advance();
    end

    // Reset in the middle of a wait
    MemReqM = 1;
    evalCycle(); advance();
    MemReqM = 0;
    evalCycle(); advance();
    doReset();
    for (int i = 0; i < 6; i++) begin
      evalCycle(); checkOutput("rstAbandon", {MemErr, stalls()}, 6'b0); advance();
    end

    // Saturation of the stall counter
    ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
    for (int i = 0; i < 20; i++) begin
      evalCycle(); advance();
    end
    checkOutput("satCount", StallCount, SAT);
    clearInputs();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 39) == 0) doReset();
      applyStimulus();
      evalCycle();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
